accel_wrapper_pow: RTL

Parametrised multi-channel accelerator wrapper: on `start` it latches an exponent code `U` and `N_CH` packed input words `V`. For each channel in turn it computes `V_i^(U+1)` with an internal iterative multiply engine. Each result is presented on a write port with a `wr_req`/`wr_ack` handshake, then `done` is pulsed. It replaces the fixed single-channel wrapper between the host-side controller and the result memory.

---
 rtl/accel_wrapper_pow_if.sv | 30 +++
 rtl/accel_wrapper_pow.sv | 122 ++++++++++++
 2 files changed

// File: rtl/accel_wrapper_pow_if.sv
// Host/result-memory bundle for accel_wrapper_pow: job launch (start/U/V),
// status (busy/done) and the wr_req/wr_ack result write port.
interface accel_wrapper_pow_if #(
    parameter int N_CH = 4,
    parameter int VW   = 5,
    parameter int UW   = 2,
    parameter int RW   = 21
);
    localparam int AW = (N_CH > 1) ? $clog2(N_CH) : 1;

    logic                 start;
    logic [UW-1:0]        U;
    logic [N_CH*VW-1:0]   V;
    logic                 wr_ack;
    logic                 busy;
    logic                 wr_req;
    logic [AW-1:0]        wr_addr;
    logic [RW-1:0]        wr_data;
    logic                 done;

    modport master (
        output start, U, V, wr_ack,
        input  busy, wr_req, wr_addr, wr_data, done
    );

    modport slave (
        input  start, U, V, wr_ack,
        output busy, wr_req, wr_addr, wr_data, done
    );
endinterface

// File: rtl/accel_wrapper_pow.sv
// Multi-channel power engine: writes V_i^(U+1) per channel via wr_req/wr_ack, then pulses done.
// Optional macro ACC_SAT_EN: saturate the accumulator on overflow instead of wrapping mod 2^RW.
module accel_wrapper_pow #(
    parameter int N_CH = 4,
    parameter int VW   = 5,
    parameter int UW   = 2,
    parameter int RW   = 21
) (
    input  logic               clk,
    input  logic               rst,
    accel_wrapper_pow_if.slave bus
);
    localparam int AW = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int PW = RW + VW;

    typedef enum logic [2:0] {IDLE, LOAD, MUL, WRITE, DONE} state_t;

    state_t             state, state_nxt;
    logic [UW-1:0]      u_lat, u_nxt;
    logic [N_CH*VW-1:0] v_lat, v_nxt;
    logic [AW-1:0]      ch, ch_nxt;
    logic [UW-1:0]      cnt, cnt_nxt;
    logic [RW-1:0]      acc, acc_nxt;

    function automatic logic [VW-1:0] word_at(input logic [N_CH*VW-1:0] v,
                                              input logic [AW-1:0] idx);
        return v[int'(idx)*VW +: VW];
    endfunction

    // One RW x VW multiply; overflow either clamps to all ones or wraps.
    function automatic logic [RW-1:0] mul_step(input logic [RW-1:0] a,
                                               input logic [VW-1:0] b);
        logic [PW-1:0] p;
        p = PW'(a) * PW'(b);
`ifdef ACC_SAT_EN
        if (|p[PW-1:RW]) return '1;
        return p[RW-1:0];
`else
        return p[RW-1:0];
`endif
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            u_lat <= '0;
            v_lat <= '0;
            ch    <= '0;
            cnt   <= '0;
            acc   <= '0;
        end else begin
            state <= state_nxt;
            u_lat <= u_nxt;
            v_lat <= v_nxt;
            ch    <= ch_nxt;
            cnt   <= cnt_nxt;
            acc   <= acc_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        u_nxt       = u_lat;
        v_nxt       = v_lat;
        ch_nxt      = ch;
        cnt_nxt     = cnt;
        acc_nxt     = acc;
        bus.busy    = 1'b1;
        bus.wr_req  = 1'b0;
        bus.wr_addr = '0;
        bus.wr_data = '0;
        bus.done    = 1'b0;

        case (state)
            IDLE: begin
                bus.busy = 1'b0;
                if (bus.start) begin
                    u_nxt     = bus.U;
                    v_nxt     = bus.V;
                    state_nxt = LOAD;
                end
            end
            LOAD: begin
                ch_nxt    = '0;
                acc_nxt   = RW'(word_at(v_lat, '0));
                cnt_nxt   = u_lat;
                state_nxt = MUL;
            end
            MUL: begin
                // cnt counts remaining multiplies; the cnt==0 cycle is the hand-off to WRITE
                if (cnt == '0) begin
                    state_nxt = WRITE;
                end else begin
                    acc_nxt = mul_step(acc, word_at(v_lat, ch));
                    cnt_nxt = cnt - 1'b1;
                end
            end
            WRITE: begin
                bus.wr_req  = 1'b1;
                bus.wr_addr = ch;
                bus.wr_data = acc;
                if (bus.wr_ack) begin
                    if (ch == AW'(N_CH - 1)) begin
                        state_nxt = DONE;
                    end else begin
                        ch_nxt    = ch + 1'b1;
                        acc_nxt   = RW'(word_at(v_lat, ch + 1'b1));
                        cnt_nxt   = u_lat;
                        state_nxt = MUL;
                    end
                end
            end
            DONE: begin
                bus.done  = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end
endmodule
